llsc_reservation_unit: RTL and testbench

//  Tracks load-linked reservations for NCORES cores and resolves store-conditional success/fail.

---
 rtl/llsc_reservation_unit.sv | 114 +++++++++++
 tb/tb_llsc_reservation_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llsc_reservation_unit.sv
// llsc_reservation_unit: per-core load-linked reservation tracking and
// store-conditional arbitration. Each core owns one reservation entry. An entry is
// invalidated by committed stores, by winning SCs, by external snoops and
// (optionally) by age. When several SCs hit the same granule in one cycle, the
// lowest-indexed core is the only one that succeeds.
module llsc_reservation_unit #(
    parameter int NCORES    = 2,
    parameter int ADDR_W    = 32,
    parameter int GRAN_BITS = 2,
    parameter int TIMEOUT   = 0,
    parameter int CNT_W     = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NCORES-1:0]              ll_req,
    input  logic [NCORES-1:0][ADDR_W-1:0]  ll_addr,
    input  logic [NCORES-1:0]              sc_req,
    input  logic [NCORES-1:0][ADDR_W-1:0]  sc_addr,
    input  logic [NCORES-1:0]              wr_valid,
    input  logic [NCORES-1:0][ADDR_W-1:0]  wr_addr,
    input  logic                           snoop_inv_valid,
    input  logic [ADDR_W-1:0]              snoop_inv_addr,
    output logic [NCORES-1:0]              sc_done,
    output logic [NCORES-1:0]              sc_ok,
    output logic [NCORES-1:0]              rsv_valid,
    output logic [NCORES-1:0][ADDR_W-1:0]  rsv_addr
);

    // Mask that clears the granule offset bits; written as a mask so that
    // GRAN_BITS=0 needs no special case.
    localparam logic [ADDR_W-1:0] GMASK = ~((ADDR_W'(1) << GRAN_BITS) - ADDR_W'(1));
    // Counter value in an entry's last live cycle (unused when TIMEOUT=0).
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    function automatic logic gmatch(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a & GMASK) == (b & GMASK);
    endfunction

    logic [NCORES-1:0] sc_pass;
    logic [NCORES-1:0] sc_win;
    logic [NCORES-1:0] kill;

    // SC evaluation on start-of-cycle state; a pass loses to any lower-indexed
    // pass on the same granule.
    always_comb begin
        sc_pass = '0;
        sc_win  = '0;
        for (int i = 0; i < NCORES; i++)
            sc_pass[i] = sc_req[i] && rsv_valid[i] && gmatch(rsv_addr[i], sc_addr[i]);
        for (int i = 0; i < NCORES; i++) begin
            sc_win[i] = sc_pass[i];
            for (int j = 0; j < NCORES; j++)
                if (j < i && sc_pass[j] && gmatch(sc_addr[j], sc_addr[i]))
                    sc_win[i] = 1'b0;
        end
    end

    // Kill sources: snoops, any core's committed store, any winning SC.
    always_comb begin
        kill = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (snoop_inv_valid && gmatch(snoop_inv_addr, rsv_addr[i]))
                kill[i] = 1'b1;
            for (int j = 0; j < NCORES; j++) begin
                if (wr_valid[j] && gmatch(wr_addr[j], rsv_addr[i]))
                    kill[i] = 1'b1;
                if (sc_win[j] && gmatch(sc_addr[j], rsv_addr[i]))
                    kill[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCORES; g++) begin : g_entry
        logic              valid_q;
        logic [ADDR_W-1:0] addr_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              done_q;
        logic              ok_q;
        logic              expire;

        assign expire = (TIMEOUT > 0) && valid_q && (cnt_q == CNT_LAST);

        // Entry update: SC/kill/timeout clear the entry, and a same-cycle LL
        // overrides all of them with a fresh reservation.
        always_ff @(posedge CLK) begin
            if (RST) begin
                valid_q <= 1'b0;
                addr_q  <= '0;
                cnt_q   <= '0;
                done_q  <= 1'b0;
                ok_q    <= 1'b0;
            end else begin
                done_q <= sc_req[g];
                ok_q   <= sc_win[g];
                if (ll_req[g]) begin
                    valid_q <= 1'b1;
                    addr_q  <= ll_addr[g] & GMASK;
                    cnt_q   <= '0;
                end else begin
                    if (sc_req[g] || kill[g] || expire)
                        valid_q <= 1'b0;
                    if (valid_q && cnt_q != '1)
                        cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign rsv_valid[g] = valid_q;
        assign rsv_addr[g]  = addr_q;
        assign sc_done[g]   = done_q;
        assign sc_ok[g]     = ok_q;
    end

endmodule

// File: tb/tb_llsc_reservation_unit.sv
// Bench for llsc_reservation_unit: two instances share stimulus, one without
// timeout and one with TIMEOUT=4. Expected SC results are queued when an SC is
// driven and compared once the registered result appears.
module tb_llsc_reservation_unit;

    logic             CLK;
    logic             RST;
    logic [1:0]       ll_req, sc_req, wr_valid;
    logic [1:0][31:0] ll_addr, sc_addr, wr_addr;
    logic             snoop_inv_valid;
    logic [31:0]      snoop_inv_addr;
    logic [1:0]       sc_done, sc_ok, rsv_valid;
    logic [1:0][31:0] rsv_addr;
    logic [1:0]       to_sc_done, to_sc_ok, to_rsv_valid;
    logic [1:0][31:0] to_rsv_addr;

    typedef struct {
        logic [1:0] done;
        logic [1:0] ok;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;

    llsc_reservation_unit #(.NCORES(2), .ADDR_W(32), .GRAN_BITS(2), .TIMEOUT(0), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .ll_req(ll_req), .ll_addr(ll_addr), .sc_req(sc_req), .sc_addr(sc_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr),
        .snoop_inv_valid(snoop_inv_valid), .snoop_inv_addr(snoop_inv_addr),
        .sc_done(sc_done), .sc_ok(sc_ok), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr)
    );

    llsc_reservation_unit #(.NCORES(2), .ADDR_W(32), .GRAN_BITS(2), .TIMEOUT(4), .CNT_W(16)) dut_to (
        .CLK(CLK), .RST(RST),
        .ll_req(ll_req), .ll_addr(ll_addr), .sc_req(sc_req), .sc_addr(sc_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr),
        .snoop_inv_valid(snoop_inv_valid), .snoop_inv_addr(snoop_inv_addr),
        .sc_done(to_sc_done), .sc_ok(to_sc_ok), .rsv_valid(to_rsv_valid), .rsv_addr(to_rsv_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net: the run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after a rising edge; outputs read then reflect that edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ll_req = '0; sc_req = '0; wr_valid = '0;
        ll_addr = '0; sc_addr = '0; wr_addr = '0;
        snoop_inv_valid = 1'b0; snoop_inv_addr = '0;
    endtask

    task automatic apply_rst();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle();
        tick(); tick();
        RST = 1'b0;
        checks++; if (sc_done !== 2'b00) begin failures++; $display("FAIL reset_sc_done: got %b expected 00", sc_done); end
        checks++; if (sc_ok !== 2'b00) begin failures++; $display("FAIL reset_sc_ok: got %b expected 00", sc_ok); end
        checks++; if (rsv_valid !== 2'b00) begin failures++; $display("FAIL reset_rsv_valid: got %b expected 00", rsv_valid); end
        checks++; if (rsv_addr !== 64'h0) begin failures++; $display("FAIL reset_rsv_addr: got %h expected 0", rsv_addr); end
    endtask

    task automatic test_basic();
        apply_rst();
        ll_req = 2'b11; ll_addr[0] = 32'h100; ll_addr[1] = 32'h10B;
        tick(); idle();
        checks++; if (rsv_valid !== 2'b11) begin failures++; $display("FAIL basic_ll_valid: got %b expected 11", rsv_valid); end
        checks++; if (rsv_addr[0] !== 32'h100) begin failures++; $display("FAIL basic_ll_addr0: got %h expected 100", rsv_addr[0]); end
        checks++; if (rsv_addr[1] !== 32'h108) begin failures++; $display("FAIL basic_ll_addr1_aligned: got %h expected 108", rsv_addr[1]); end
        tick();
        sc_req = 2'b01; sc_addr[0] = 32'h100;
        sbq.push_back('{done: 2'b01, ok: 2'b01});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done) begin failures++; $display("FAIL basic_sc_done: got %b expected %b", sc_done, e.done); end
        checks++; if (sc_ok !== e.ok) begin failures++; $display("FAIL basic_sc_ok: got %b expected %b", sc_ok, e.ok); end
        checks++; if (rsv_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_rsv_cleared: got %b expected 0", rsv_valid[0]); end
        tick();
        checks++; if (sc_done !== 2'b00) begin failures++; $display("FAIL basic_done_pulse: got %b expected 00", sc_done); end
    endtask

    task automatic test_cross_kill();
        apply_rst();
        ll_req = 2'b01; ll_addr[0] = 32'h100;
        tick(); idle();
        wr_valid = 2'b10; wr_addr[1] = 32'h104;
        tick(); idle();
        checks++; if (rsv_valid[0] !== 1'b1) begin failures++; $display("FAIL kill_other_granule: got %b expected 1", rsv_valid[0]); end
        wr_valid = 2'b10; wr_addr[1] = 32'h102;
        tick(); idle();
        checks++; if (rsv_valid[0] !== 1'b0) begin failures++; $display("FAIL kill_same_granule: got %b expected 0", rsv_valid[0]); end
        sc_req = 2'b01; sc_addr[0] = 32'h100;
        sbq.push_back('{done: 2'b01, ok: 2'b00});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done || sc_ok !== e.ok) begin failures++; $display("FAIL kill_sc: got done=%b ok=%b expected done=%b ok=%b", sc_done, sc_ok, e.done, e.ok); end
        ll_req = 2'b01; ll_addr[0] = 32'h100;
        tick(); idle();
        wr_valid = 2'b01; wr_addr[0] = 32'h100;
        tick(); idle();
        checks++; if (rsv_valid[0] !== 1'b0) begin failures++; $display("FAIL kill_own_store: got %b expected 0", rsv_valid[0]); end
        ll_req = 2'b01; ll_addr[0] = 32'h100;
        tick(); idle();
        snoop_inv_valid = 1'b1; snoop_inv_addr = 32'h101;
        tick(); idle();
        checks++; if (rsv_valid[0] !== 1'b0) begin failures++; $display("FAIL kill_snoop: got %b expected 0", rsv_valid[0]); end
    endtask

    task automatic test_race();
        apply_rst();
        ll_req = 2'b11; ll_addr[0] = 32'h200; ll_addr[1] = 32'h200;
        tick(); idle();
        checks++; if (rsv_valid !== 2'b11) begin failures++; $display("FAIL race_ll_valid: got %b expected 11", rsv_valid); end
        sc_req = 2'b11; sc_addr[0] = 32'h200; sc_addr[1] = 32'h200;
        sbq.push_back('{done: 2'b11, ok: 2'b01});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done || sc_ok !== e.ok) begin failures++; $display("FAIL race_same: got done=%b ok=%b expected done=%b ok=%b", sc_done, sc_ok, e.done, e.ok); end
        sc_req = 2'b10; sc_addr[1] = 32'h200;
        sbq.push_back('{done: 2'b10, ok: 2'b00});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done || sc_ok !== e.ok) begin failures++; $display("FAIL race_late_c1: got done=%b ok=%b expected done=%b ok=%b", sc_done, sc_ok, e.done, e.ok); end
        // Distinct granules: both succeed.
        ll_req = 2'b11; ll_addr[0] = 32'h200; ll_addr[1] = 32'h300;
        tick(); idle();
        sc_req = 2'b11; sc_addr[0] = 32'h200; sc_addr[1] = 32'h300;
        sbq.push_back('{done: 2'b11, ok: 2'b11});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done || sc_ok !== e.ok) begin failures++; $display("FAIL race_distinct: got done=%b ok=%b expected done=%b ok=%b", sc_done, sc_ok, e.done, e.ok); end
        // A winning SC from c1 kills c0's reservation on the same granule.
        ll_req = 2'b11; ll_addr[0] = 32'h400; ll_addr[1] = 32'h400;
        tick(); idle();
        sc_req = 2'b10; sc_addr[1] = 32'h400;
        sbq.push_back('{done: 2'b10, ok: 2'b10});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done || sc_ok !== e.ok) begin failures++; $display("FAIL race_c1_alone: got done=%b ok=%b expected done=%b ok=%b", sc_done, sc_ok, e.done, e.ok); end
        checks++; if (rsv_valid !== 2'b00) begin failures++; $display("FAIL race_win_kills: got %b expected 00", rsv_valid); end
    endtask

    task automatic test_timeout();
        apply_rst();
        ll_req = 2'b01; ll_addr[0] = 32'h100;
        tick(); idle();
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (to_rsv_valid[0] !== (k <= 4)) begin
                failures++;
                $display("FAIL timeout_valid_cycle%0d: got %b expected %b", k, to_rsv_valid[0], (k <= 4));
            end
            if (k < 6) tick();
        end
        checks++; if (rsv_valid[0] !== 1'b1) begin failures++; $display("FAIL no_timeout_persists: got %b expected 1", rsv_valid[0]); end
        // SC in the last live cycle succeeds.
        apply_rst();
        ll_req = 2'b01; ll_addr[0] = 32'h100;
        tick(); idle();
        tick(); tick(); tick();
        sc_req = 2'b01; sc_addr[0] = 32'h100;
        sbq.push_back('{done: 2'b01, ok: 2'b01});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (to_sc_done !== e.done || to_sc_ok !== e.ok) begin failures++; $display("FAIL timeout_sc_c4: got done=%b ok=%b expected done=%b ok=%b", to_sc_done, to_sc_ok, e.done, e.ok); end
        // SC one cycle after expiry fails.
        apply_rst();
        ll_req = 2'b01; ll_addr[0] = 32'h100;
        tick(); idle();
        tick(); tick(); tick(); tick();
        sc_req = 2'b01; sc_addr[0] = 32'h100;
        sbq.push_back('{done: 2'b01, ok: 2'b00});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (to_sc_done !== e.done || to_sc_ok !== e.ok) begin failures++; $display("FAIL timeout_sc_c5: got done=%b ok=%b expected done=%b ok=%b", to_sc_done, to_sc_ok, e.done, e.ok); end
    endtask

    task automatic test_simultaneous();
        apply_rst();
        ll_req = 2'b10; ll_addr[1] = 32'h300;
        snoop_inv_valid = 1'b1; snoop_inv_addr = 32'h300;
        tick(); idle();
        checks++; if (rsv_valid[1] !== 1'b1) begin failures++; $display("FAIL ll_beats_snoop: got %b expected 1", rsv_valid[1]); end
        sc_req = 2'b01; sc_addr[0] = 32'h500;
        sbq.push_back('{done: 2'b01, ok: 2'b00});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done || sc_ok !== e.ok) begin failures++; $display("FAIL sc_no_ll: got done=%b ok=%b expected done=%b ok=%b", sc_done, sc_ok, e.done, e.ok); end
        // LL and SC on one core in one cycle: SC uses old state, LL sets new one.
        ll_req = 2'b01; ll_addr[0] = 32'h600;
        tick(); idle();
        ll_req = 2'b01; ll_addr[0] = 32'h700;
        sc_req = 2'b01; sc_addr[0] = 32'h600;
        sbq.push_back('{done: 2'b01, ok: 2'b01});
        tick(); idle();
        e = sbq.pop_front();
        checks++; if (sc_done !== e.done || sc_ok !== e.ok) begin failures++; $display("FAIL ll_sc_same_cycle: got done=%b ok=%b expected done=%b ok=%b", sc_done, sc_ok, e.done, e.ok); end
        checks++; if (rsv_valid[0] !== 1'b1 || rsv_addr[0] !== 32'h700) begin failures++; $display("FAIL ll_sc_new_rsv: got v=%b a=%h expected v=1 a=700", rsv_valid[0], rsv_addr[0]); end
    endtask

    task automatic test_reset_mid();
        apply_rst();
        ll_req = 2'b11; ll_addr[0] = 32'h100; ll_addr[1] = 32'h200;
        tick(); idle();
        RST = 1'b1;
        sc_req = 2'b01; sc_addr[0] = 32'h100;
        tick(); idle();
        RST = 1'b0;
        checks++; if (sc_done !== 2'b00 || sc_ok !== 2'b00) begin failures++; $display("FAIL midrst_no_done: got done=%b ok=%b expected 00/00", sc_done, sc_ok); end
        checks++; if (rsv_valid !== 2'b00 || rsv_addr !== 64'h0) begin failures++; $display("FAIL midrst_cleared: got v=%b a=%h expected 0", rsv_valid, rsv_addr); end
        tick();
        checks++; if (sc_done !== 2'b00) begin failures++; $display("FAIL midrst_late_done: got %b expected 00", sc_done); end
    endtask

    initial begin
        RST = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_cross_kill();
        test_race();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
